encoder_4to2_sync: RTL
======================

// Module: encoder_4to2_sync
// PURPOSE
//   Registered 4-to-2 priority encoder; inverse of the active-low 2-to-4 decoder.
//   Samples four active-low request lines, synchronises and debounces them, then
//   presents the 2-bit code of the highest-priority active line on {A,B}.
//   The code is held with a valid/ack handshake. Sits between async request
//   sources (switches, decoder outputs) and clocked datapath logic.
// PARAMETERS
//   DEBOUNCE  4  consecutive stable synchronised samples required; legal 1..7
//   CNT_W     3  debounce counter width; must hold the value DEBOUNCE
// PORTS
//   clk     in   1  rising-edge clock, single clock domain
//   resetn  in   1  asynchronous, active-low reset
//   D3      in   1  request 3, active-low, async; highest priority
//   D2      in   1  request 2, active-low, async
//   D1      in   1  request 1, active-low, async
//   D0      in   1  request 0, active-low, async; lowest priority
//   en      in   1  encoder enable, active-high, synchronous
//   ack     in   1  consumer accepts the code; sampled only in HOLD
//   A       out  1  code MSB, registered
//   B       out  1  code LSB, registered
//   valid   out  1  {A,B} holds a debounced, unacknowledged code
//   busy    out  1  high in DEBOUNCE, HOLD and RELEASE
// BEHAVIOUR
//   Reset (resetn=0, async): sync flops=4'b1111; A=0, B=0, valid=0, busy=0;
//     cnt=0; state=IDLE.
//   Sync: 2-flop synchroniser per D line. act[3:0] = ~sync2 & {4{en}}.
//   Priority code (pcode): act[3]->11, act[2]->10, act[1]->01, else 00.
//   FSM, all transitions on the rising clk edge:
//     IDLE: if act!=0, then cand=pcode and cnt=1. Go to DEBOUNCE, or go
//       straight to HOLD if DEBOUNCE==1.
//     DEBOUNCE: if act==0 or pcode!=cand, then cnt=0 and go to IDLE.
//       Else cnt++. When cnt reaches DEBOUNCE: {A,B}=cand, valid=1, go to HOLD.
//       A higher-priority line joining mid-count therefore restarts debounce.
//     HOLD: valid=1; {A,B} stable. If ack=1, then valid=0 and go to RELEASE.
//       ack is accepted in the first cycle valid is high.
//     RELEASE: wait until act==0, then go to IDLE.
//       No new code is produced while any line stays held.
//   Latency: pins stable low from before edge 1 -> valid high after edge
//     DEBOUNCE+2 (DEBOUNCE=4 -> edge 6).
//   en=0 in any state: next edge goes to IDLE, valid=0, cnt=0.
//     An unacked code is discarded; A and B retain their last value.
//   ack outside HOLD is ignored. A, B, valid and busy are glitch-free registers.
//   Simultaneous ack and en=0: en=0 wins; result is IDLE.
//   Reset mid-operation: immediate clear. A line still held after release
//     re-debounces from scratch.
// CONFIGURATION
//   ENC_MULTI_ERR_EN defined: adds output multi_err (out, 1, registered,
//     resets to 0). Set together with valid when more than one act bit is 1
//     at that edge. Cleared whenever valid clears.
//   ENC_MULTI_ERR_EN undefined: port and logic are absent; all other
//     behaviour is identical.
// TESTING
//   1 Reset: resetn=0 with D=4'b0000 -> A=0, B=0, valid=0, busy=0,
//     multi_err=0, held until resetn=1.
//   2 D=4'b1011, en=1, DEBOUNCE=4 -> valid=1 after edge 6, {A,B}=2'b10;
//     ack=1 at edge 9 -> valid=0; busy stays 1 until D=4'b1111.
//   3 D=4'b0110 -> {A,B}=2'b11, valid=1; multi_err=1 with ENC_MULTI_ERR_EN.
//   4 D0 low for 2 cycles, then high -> valid never asserts; FSM back in IDLE.
//   5 D1 held low, D3 driven low at cnt=2 -> restart; valid after 4 further
//     stable edges with {A,B}=2'b11.
//   6 en=0 during HOLD -> valid=0 next edge. resetn pulsed mid-DEBOUNCE ->
//     outputs cleared at once; held line yields valid DEBOUNCE+2 edges
//     after release.

Source files
------------

// File: rtl/encoder_4to2_sync.sv
// encoder_4to2_sync
//   Registered 4-to-2 priority encoder for asynchronous active-low request lines.
//   Each line passes through a 2-flop synchroniser. The highest-priority active
//   line must hold the same code for DEBOUNCE consecutive samples. Its 2-bit code
//   is then presented on {A,B} and held with a valid/ack handshake.
//
//   Optional feature macro: ENC_MULTI_ERR_EN adds the multi_err output. It flags
//   that more than one request was active when the code was published.
//
// Ports
//   clk        in   rising-edge clock
//   resetn     in   asynchronous active-low reset
//   D3..D0     in   active-low async requests, D3 highest priority
//   en         in   synchronous encoder enable (active-high)
//   ack        in   consumer accepts the code (only honoured while holding)
//   A, B       out  registered code MSB/LSB
//   valid      out  {A,B} carries a debounced, unacknowledged code
//   busy       out  encoder is debouncing, holding or waiting for release
//   multi_err  out  (ENC_MULTI_ERR_EN only) multiple requests at publish time

module encoder_4to2_sync #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic D3,
  input  logic D2,
  input  logic D1,
  input  logic D0,
  input  logic en,
  input  logic ack,
  output logic A,
  output logic B,
  output logic valid,
`ifdef ENC_MULTI_ERR_EN
  output logic multi_err,
`endif
  output logic busy
);

  localparam int unsigned NREQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  logic [NREQ-1:0]  pins_c;
  logic [NREQ-1:0]  sync1_q, sync2_q;
  logic [NREQ-1:0]  act_c;
  logic [1:0]       pcode_c;
  logic [CNT_W-1:0] cnt_inc_c;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cand_q, cand_d;
  logic [1:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  assign pins_c = {D3, D2, D1, D0};

  // Two-flop synchroniser; idle (all high) out of reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= {NREQ{1'b1}};
      sync2_q <= {NREQ{1'b1}};
    end else begin
      sync1_q <= pins_c;
      sync2_q <= sync1_q;
    end
  end

  // Active requests, masked by the enable.
  assign act_c = ~sync2_q & {NREQ{en}};

  // Priority code of the highest active line.
  always_comb begin
    pcode_c = 2'b00;
    if (act_c[3])      pcode_c = 2'b11;
    else if (act_c[2]) pcode_c = 2'b10;
    else if (act_c[1]) pcode_c = 2'b01;
  end

  assign cnt_inc_c = cnt_q + CNT_W'(1);

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = valid_q;

    if (!en) begin
      // Disable discards any unacked code; A/B keep their last value.
      state_d = ST_IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (act_c != '0) begin
            cand_d = pcode_c;
            cnt_d  = CNT_W'(1);
            if (DEBOUNCE == 32'd1) begin
              code_d  = pcode_c;
              valid_d = 1'b1;
              state_d = ST_HOLD;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          // Any change of winning line (including a higher one joining) restarts.
          if ((act_c == '0) || (pcode_c != cand_q)) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_inc_c;
            if (cnt_inc_c == CNT_W'(DEBOUNCE)) begin
              code_d  = cand_q;
              valid_d = 1'b1;
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (ack) begin
            valid_d = 1'b0;
            state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          // A still-held line must be released before a new code can form.
          if (act_c == '0) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        default: begin
          cnt_d   = '0;
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cand_q  <= 2'b00;
      code_q  <= 2'b00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign A     = code_q[1];
  assign B     = code_q[0];
  assign valid = valid_q;
  assign busy  = busy_q;

`ifdef ENC_MULTI_ERR_EN
  logic multi_c;
  logic merr_q, merr_d;

  // More than one bit set: clearing the lowest set bit leaves a nonzero value.
  assign multi_c = ((act_c & (act_c - NREQ'(1))) != '0);

  // Captured on the edge valid rises, dropped whenever valid drops.
  always_comb begin
    merr_d = merr_q;
    if (!valid_d)      merr_d = 1'b0;
    else if (!valid_q) merr_d = multi_c;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) merr_q <= 1'b0;
    else         merr_q <= merr_d;
  end

  assign multi_err = merr_q;
`endif

endmodule
